// File: rtl/cpu_bus_pkg.sv
// Shared bus widths and active-low strobe levels for the CPU bus blocks.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cpu_bus_pkg;

    localparam int WIDTH_AX   = 16;
    localparam int WIDTH_MAIN = 8;

    localparam logic ASSERTED = 1'b0;
    localparam logic IDLE     = 1'b1;

    function automatic logic strobe_on(input logic strobe);
        return strobe == ASSERTED;
    endfunction

endpackage

// File: rtl/addr_counter.sv
// One address register: load > count (+/- step) > post-increment, with carry/borrow wrap detect.
// Latency: one edge for every update; wrap pulses the cycle after the wrapping edge.
// Backpressure: none, every hit is applied at the next edge.
module addr_counter #(
    parameter int               WIDTH       = 16,
    parameter int               STEP_W      = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_hit,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              cnt_hit,
    input  logic              cnt_dn,
    input  logic [STEP_W-1:0] step,
    input  logic              pinc_hit,
    output logic [WIDTH-1:0]  value,
    output logic              wrap
);

    logic [WIDTH-1:0] val_q, val_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH:0]   sum;

    // The extra top bit of sum is the carry out on add and the borrow on subtract.
    always_comb begin
        val_d  = val_q;
        wrap_d = 1'b0;
        sum    = '0;
        if (load_hit) begin
            val_d = load_val;
        end else if (cnt_hit) begin
            if (cnt_dn) begin
                sum = {1'b0, val_q} - (WIDTH+1)'(step);
            end else begin
                sum = {1'b0, val_q} + (WIDTH+1)'(step);
            end
            val_d  = sum[WIDTH-1:0];
            wrap_d = sum[WIDTH];
        end else if (pinc_hit) begin
            sum    = {1'b0, val_q} + (WIDTH+1)'(1);
            val_d  = sum[WIDTH-1:0];
            wrap_d = sum[WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q  <= RESET_VALUE;
            wrap_q <= 1'b0;
        end else begin
            val_q  <= val_d;
            wrap_q <= wrap_d;
        end
    end

    assign value = val_q;
    assign wrap  = wrap_q;

endmodule

// File: rtl/register_addr_bank.sv
// Clocked bank of address registers with load, step count, post-increment and two bus drivers.
// Latency: updates take one edge; bus outputs are combinational from register state.
// Backpressure: none; out-of-range selects are ignored for writes and drive 0 on reads.
module register_addr_bank
    import cpu_bus_pkg::*;
#(
    parameter int               WIDTH       = WIDTH_AX,
    parameter int               COUNT       = 4,
    parameter int               SEL_W       = $clog2(COUNT),
    parameter int               STEP_W      = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  xfer_in,
    input  logic [SEL_W-1:0]  load_sel,
    input  logic              load_xfer,
    input  logic [SEL_W-1:0]  cnt_sel,
    input  logic              inc,
    input  logic              dec,
    input  logic [STEP_W-1:0] step,
    input  logic [SEL_W-1:0]  addr_sel,
    input  logic              assert_addr,
    input  logic              postinc,
    output logic [WIDTH-1:0]  addr_out,
    output logic              addr_en,
    input  logic [SEL_W-1:0]  xfer_sel,
    input  logic              assert_xfer,
    output logic [WIDTH-1:0]  xfer_out,
    output logic              xfer_en,
    output logic              wrap,
    output logic              fault
);

    logic [WIDTH-1:0] regs [COUNT];
    logic [COUNT-1:0] wrap_vec;
    logic             inc_on, dec_on, cnt_on, pinc_on;
    logic             fault_q, fault_d;

    assign inc_on  = strobe_on(inc);
    assign dec_on  = strobe_on(dec);
    assign cnt_on  = inc_on ^ dec_on;
    assign pinc_on = strobe_on(assert_addr) && strobe_on(postinc);

    // Decode compares against in-range indices only, so out-of-range selects hit nothing.
    for (genvar i = 0; i < COUNT; i++) begin : g_reg
        addr_counter #(
            .WIDTH       (WIDTH),
            .STEP_W      (STEP_W),
            .RESET_VALUE (RESET_VALUE)
        ) u_cnt (
            .clk      (clk),
            .rst_n    (reset),
            .load_hit (strobe_on(load_xfer) && (load_sel == SEL_W'(i))),
            .load_val (xfer_in),
            .cnt_hit  (cnt_on && (cnt_sel == SEL_W'(i))),
            .cnt_dn   (dec_on),
            .step     (step),
            .pinc_hit (pinc_on && (addr_sel == SEL_W'(i))),
            .value    (regs[i]),
            .wrap     (wrap_vec[i])
        );
    end

    assign addr_en = strobe_on(assert_addr);
    assign xfer_en = strobe_on(assert_xfer);

    always_comb begin
        addr_out = '0;
        xfer_out = '0;
        for (int i = 0; i < COUNT; i++) begin
            if (addr_en && (addr_sel == SEL_W'(i))) addr_out = regs[i];
            if (xfer_en && (xfer_sel == SEL_W'(i))) xfer_out = regs[i];
        end
    end

    always_comb begin
        fault_d = fault_q | (inc_on & dec_on);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign wrap  = |wrap_vec;
    assign fault = fault_q;

endmodule

// File: tb/tb_register_addr_bank.sv
// Directed vector table, hand sequences for multi-cycle cases, then random stimulus vs a model.
module tb_register_addr_bank;

    localparam int NREG = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] xfer_in;
    logic [2:0]  load_sel, cnt_sel, addr_sel, xfer_sel;
    logic        load_xfer, inc, dec, assert_addr, postinc, assert_xfer;
    logic [3:0]  step;
    logic [15:0] addr_out, xfer_out;
    logic        addr_en, xfer_en, wrap, fault;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    register_addr_bank #(
        .WIDTH  (16),
        .COUNT  (NREG),
        .STEP_W (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .xfer_in     (xfer_in),
        .load_sel    (load_sel),
        .load_xfer   (load_xfer),
        .cnt_sel     (cnt_sel),
        .inc         (inc),
        .dec         (dec),
        .step        (step),
        .addr_sel    (addr_sel),
        .assert_addr (assert_addr),
        .postinc     (postinc),
        .addr_out    (addr_out),
        .addr_en     (addr_en),
        .xfer_sel    (xfer_sel),
        .assert_xfer (assert_xfer),
        .xfer_out    (xfer_out),
        .xfer_en     (xfer_en),
        .wrap        (wrap),
        .fault       (fault)
    );

    typedef struct {
        logic        ld_n;  logic [2:0] ld_sel; logic [15:0] xin;
        logic        inc_n; logic dec_n; logic [2:0] c_sel; logic [3:0] stp;
        logic        aa_n;  logic [2:0] a_sel;  logic pi_n;
        logic        ax_n;  logic [2:0] x_sel;
        logic [15:0] e_addr; logic e_aen; logic [15:0] e_xfer; logic e_xen;
        logic        e_wrap; logic e_fault;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int ld_n, int ld_sel, int xin, int inc_n, int dec_n, int c_sel,
                                int stp, int aa_n, int a_sel, int pi_n, int ax_n, int x_sel,
                                int e_addr, int e_aen, int e_xfer, int e_xen, int e_wrap,
                                int e_fault);
        vec_t v;
        v.ld_n = 1'(ld_n);   v.ld_sel = 3'(ld_sel); v.xin = 16'(xin);
        v.inc_n = 1'(inc_n); v.dec_n = 1'(dec_n);   v.c_sel = 3'(c_sel); v.stp = 4'(stp);
        v.aa_n = 1'(aa_n);   v.a_sel = 3'(a_sel);   v.pi_n = 1'(pi_n);
        v.ax_n = 1'(ax_n);   v.x_sel = 3'(x_sel);
        v.e_addr = 16'(e_addr); v.e_aen = 1'(e_aen); v.e_xfer = 16'(e_xfer); v.e_xen = 1'(e_xen);
        v.e_wrap = 1'(e_wrap);  v.e_fault = 1'(e_fault);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        load_xfer = 1'b1; load_sel = 3'd0; xfer_in = 16'h0;
        inc = 1'b1; dec = 1'b1; cnt_sel = 3'd0; step = 4'd0;
        assert_addr = 1'b1; addr_sel = 3'd0; postinc = 1'b1;
        assert_xfer = 1'b1; xfer_sel = 3'd0;
    endtask

    task automatic apply(input vec_t v);
        load_xfer = v.ld_n; load_sel = v.ld_sel; xfer_in = v.xin;
        inc = v.inc_n; dec = v.dec_n; cnt_sel = v.c_sel; step = v.stp;
        assert_addr = v.aa_n; addr_sel = v.a_sel; postinc = v.pi_n;
        assert_xfer = v.ax_n; xfer_sel = v.x_sel;
    endtask

    // Reference model state: plain integers, wrap judged by leaving 0..65535.
    int m[NREG];
    int nv[NREG];
    int t;
    bit mw, mf, nw;

    initial begin
        idle();
        reset = 1'b0;
        #8;
        check("rst_wrap", 32'(wrap), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        #14;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            assert_addr = 1'b0; addr_sel = 3'(i);
            #1;
            check($sformatf("rst_r%0d_addr", i), 32'(addr_out), 32'h0);
            check($sformatf("rst_r%0d_aen", i), 32'(addr_en), 32'd1);
        end
        assert_addr = 1'b1;
        #1;
        check("idle_addr", 32'(addr_out), 32'h0);
        check("idle_aen", 32'(addr_en), 32'd0);

        vecs.push_back(mk(0,1,'h5555, 1,1,0,0, 1,0,1, 0,1, 0,0,'h5555,1,0,0));
        vecs.push_back(mk(1,0,0,      0,1,1,1, 1,0,1, 0,1, 0,0,'h5556,1,0,0));
        vecs.push_back(mk(1,0,0,      1,0,1,4, 1,0,1, 0,1, 0,0,'h5552,1,0,0));
        vecs.push_back(mk(0,2,'hFFFF, 1,1,0,0, 1,0,1, 0,2, 0,0,'hFFFF,1,0,0));
        vecs.push_back(mk(1,0,0,      0,1,2,2, 1,0,1, 0,2, 0,0,'h0001,1,1,0));
        vecs.push_back(mk(1,0,0,      1,1,0,0, 1,0,1, 0,2, 0,0,'h0001,1,0,0));
        vecs.push_back(mk(1,0,0,      1,0,2,2, 1,0,1, 0,2, 0,0,'hFFFF,1,1,0));
        vecs.push_back(mk(1,0,0,      1,1,0,0, 0,2,1, 1,0, 'hFFFF,1,0,0,0,0));
        vecs.push_back(mk(0,6,'h1234, 0,1,7,3, 0,6,0, 0,5, 0,1,0,1,0,0));
        vecs.push_back(mk(1,0,0,      1,1,0,0, 0,0,1, 0,4, 0,1,0,1,0,0));
        vecs.push_back(mk(1,0,0,      0,1,1,0, 1,0,1, 0,1, 0,0,'h5552,1,0,0));
        vecs.push_back(mk(0,3,'h0010, 1,1,0,0, 0,3,1, 1,0, 'h0010,1,0,0,0,0));
        vecs.push_back(mk(1,0,0,      0,0,3,1, 0,3,1, 1,0, 'h0010,1,0,0,0,1));
        vecs.push_back(mk(0,2,'h2222, 1,1,0,0, 0,2,1, 1,0, 'h2222,1,0,0,0,1));
        vecs.push_back(mk(0,1,'h1111, 0,1,2,1, 0,3,1, 0,2, 'h0010,1,'h2223,1,0,1));
        vecs.push_back(mk(1,0,0,      1,1,0,0, 0,1,1, 1,0, 'h1111,1,0,0,0,1));
        vecs.push_back(mk(0,4,'hABCD, 0,0,4,3, 1,0,1, 0,4, 0,0,'hABCD,1,0,1));

        @(posedge clk); #1;
        foreach (vecs[i]) begin
            apply(vecs[i]);
            @(posedge clk); #1;
            check($sformatf("row%0d_addr", i), 32'(addr_out), 32'(vecs[i].e_addr));
            check($sformatf("row%0d_aen", i), 32'(addr_en), 32'(vecs[i].e_aen));
            check($sformatf("row%0d_xfer", i), 32'(xfer_out), 32'(vecs[i].e_xfer));
            check($sformatf("row%0d_xen", i), 32'(xfer_en), 32'(vecs[i].e_xen));
            check($sformatf("row%0d_wrap", i), 32'(wrap), 32'(vecs[i].e_wrap));
            check($sformatf("row%0d_fault", i), 32'(fault), 32'(vecs[i].e_fault));
        end

        // Fetch-and-advance on r0, then load beats postinc on the same register.
        idle();
        load_xfer = 1'b0; load_sel = 3'd0; xfer_in = 16'h1000;
        @(posedge clk); #1;
        idle();
        assert_addr = 1'b0; addr_sel = 3'd0; postinc = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("pinc%0d_addr", k), 32'(addr_out), 32'(16'h1000 + 16'(k)));
            @(posedge clk); #1;
        end
        postinc = 1'b1;
        #1;
        check("pinc_final", 32'(addr_out), 32'h1003);
        load_xfer = 1'b0; xfer_in = 16'h2000; postinc = 1'b0;
        @(posedge clk); #1;
        load_xfer = 1'b1; postinc = 1'b1;
        #1;
        check("pinc_load_wins", 32'(addr_out), 32'h2000);

        // Postinc carrying out of FFFF raises wrap for one cycle.
        idle();
        load_xfer = 1'b0; load_sel = 3'd4; xfer_in = 16'hFFFF;
        @(posedge clk); #1;
        idle();
        assert_addr = 1'b0; addr_sel = 3'd4; postinc = 1'b0;
        @(posedge clk); #1;
        postinc = 1'b1;
        #1;
        check("pinc_wrap_addr", 32'(addr_out), 32'h0);
        check("pinc_wrap_set", 32'(wrap), 32'd1);
        @(posedge clk); #1;
        check("pinc_wrap_clr", 32'(wrap), 32'd0);
        check("fault_sticky", 32'(fault), 32'd1);

        // Asynchronous reset between edges.
        idle();
        assert_addr = 1'b0; addr_sel = 3'd1; assert_xfer = 1'b0; xfer_sel = 3'd2;
        #1;
        check("pre_areset_r1", 32'(addr_out), 32'h1111);
        #1;
        reset = 1'b0;
        #1;
        check("areset_r1", 32'(addr_out), 32'h0);
        check("areset_r2", 32'(xfer_out), 32'h0);
        check("areset_fault", 32'(fault), 32'd0);
        load_xfer = 1'b0; load_sel = 3'd1; xfer_in = 16'h7777;
        @(posedge clk); #1;
        check("areset_hold", 32'(addr_out), 32'h0);
        idle();
        #2;
        reset = 1'b1;

        // Random traffic against the integer model, starting from reset state.
        foreach (m[r]) m[r] = 0;
        mw = 1'b0; mf = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            load_xfer   = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            load_sel    = 3'($urandom_range(0, 7));
            xfer_in     = ($urandom_range(0, 2) == 0) ? 16'(16'hFFF0 + 16'($urandom_range(0, 15)))
                                                      : 16'($urandom);
            inc         = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            dec         = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            if (c < 150) dec = dec | ~inc;
            cnt_sel     = 3'($urandom_range(0, 7));
            step        = 4'($urandom_range(0, 15));
            assert_addr = ($urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
            addr_sel    = 3'($urandom_range(0, 7));
            postinc     = ($urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
            assert_xfer = ($urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
            xfer_sel    = 3'($urandom_range(0, 7));
            #2;
            t = 0;
            if (!assert_addr && int'(addr_sel) < NREG) t = m[int'(addr_sel)];
            check("rnd_addr", 32'(addr_out), 32'(t));
            check("rnd_aen", 32'(addr_en), 32'(!assert_addr));
            t = 0;
            if (!assert_xfer && int'(xfer_sel) < NREG) t = m[int'(xfer_sel)];
            check("rnd_xfer", 32'(xfer_out), 32'(t));
            check("rnd_xen", 32'(xfer_en), 32'(!assert_xfer));
            check("rnd_wrap", 32'(wrap), 32'(mw));
            check("rnd_fault", 32'(fault), 32'(mf));

            nw = 1'b0;
            if (!inc && !dec) mf = 1'b1;
            for (int r = 0; r < NREG; r++) begin
                nv[r] = m[r];
                if (!load_xfer && int'(load_sel) == r) begin
                    nv[r] = int'(xfer_in);
                end else if ((inc != dec) && int'(cnt_sel) == r) begin
                    t = !inc ? m[r] + int'(step) : m[r] - int'(step);
                    if (t < 0 || t > 65535) nw = 1'b1;
                    nv[r] = (t + 65536) % 65536;
                end else if (!assert_addr && !postinc && int'(addr_sel) == r) begin
                    t = m[r] + 1;
                    if (t > 65535) nw = 1'b1;
                    nv[r] = t % 65536;
                end
            end
            foreach (m[r]) m[r] = nv[r];
            mw = nw;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
